gcn_aggregation_engine: RTL and testbench

//   Aggregation stage of the GCN layer, directly downstream of the transformation stage.

---
 rtl/gcn_aggregation_engine_if.sv | 36 +++
 rtl/gcn_aggregation_engine.sv | 148 ++++++++++++++
 tb/tb_gcn_aggregation_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gcn_aggregation_engine_if.sv
// Bus between the aggregation engine and its surroundings: run control, the
// COO edge memory port, the FM*WM row port and the aggregated result.
interface gcn_aggregation_engine_if #(
    parameter int FEATURE_ROWS = 6,
    parameter int WEIGHT_COLS  = 3,
    parameter int NUM_EDGES    = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int NODE_WIDTH   = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
    parameter int EDGE_WIDTH   = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
);
    logic                                          start;
    logic [EDGE_WIDTH-1:0]                         coo_address;
    logic                                          coo_read_en;
    logic [NODE_WIDTH-1:0]                         coo_src;
    logic [NODE_WIDTH-1:0]                         coo_dst;
    logic [NODE_WIDTH-1:0]                         fm_wm_row_addr;
    logic                                          fm_wm_read_en;
    logic [WEIGHT_COLS*DATA_WIDTH-1:0]             fm_wm_row_data;
    logic [FEATURE_ROWS*WEIGHT_COLS*DATA_WIDTH-1:0] agg_matrix;
    logic                                          edge_error;
    logic                                          done;

    // Engine side: issues memory reads and presents the result.
    modport master (
        input  start, coo_src, coo_dst, fm_wm_row_data,
        output coo_address, coo_read_en, fm_wm_row_addr, fm_wm_read_en,
        output agg_matrix, edge_error, done
    );

    // Environment side: memories, upstream start and downstream consumer.
    modport slave (
        output start, coo_src, coo_dst, fm_wm_row_data,
        input  coo_address, coo_read_en, fm_wm_row_addr, fm_wm_read_en,
        input  agg_matrix, edge_error, done
    );
endinterface

// File: rtl/gcn_aggregation_engine.sv
// GCN aggregation stage: walks a COO edge list of an undirected graph and
// accumulates AGG = A * (FM*WM), one edge every four cycles.
//
// state      | meaning
// IDLE       | waiting for start
// CLEAR      | zero AGG, edge counter and error flag
// FETCH_EDGE | read edge memory at edge_cnt
// LATCH_EDGE | capture endpoints, read FM*WM row of src
// ADD_DST    | AGG[dst] += row(src), read FM*WM row of dst
// ADD_SRC    | AGG[src] += row(dst) unless self-loop, advance
// DONE       | result stable, held until reset
module gcn_aggregation_engine #(
    parameter int FEATURE_ROWS = 6,
    parameter int WEIGHT_COLS  = 3,
    parameter int NUM_EDGES    = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int NODE_WIDTH   = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
    parameter int EDGE_WIDTH   = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    gcn_aggregation_engine_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH_EDGE, LATCH_EDGE, ADD_DST, ADD_SRC, DONE
    } state_t;

    localparam logic [EDGE_WIDTH-1:0] LAST_EDGE = EDGE_WIDTH'(NUM_EDGES - 1);
    // One extra bit so the range check also works when FEATURE_ROWS is a power of two.
    localparam logic [NODE_WIDTH:0]   ROWS_EXT  = (NODE_WIDTH + 1)'(FEATURE_ROWS);

    state_t                 state, state_nxt;
    logic [EDGE_WIDTH-1:0]  edge_cnt;
    logic [NODE_WIDTH-1:0]  src_q, dst_q;
    logic                   bad_q;
    logic                   edge_error_q;
    logic [EDGE_WIDTH-1:0]  coo_addr, coo_addr_q;
    logic [NODE_WIDTH-1:0]  fm_addr, fm_addr_q;
    logic                   coo_rd, fm_rd;
    logic                   edge_oor;
    logic [DATA_WIDTH-1:0]  agg [FEATURE_ROWS][WEIGHT_COLS];
    logic [FEATURE_ROWS*WEIGHT_COLS*DATA_WIDTH-1:0] agg_flat;

    assign edge_oor = ({1'b0, bus.coo_src} >= ROWS_EXT) || ({1'b0, bus.coo_dst} >= ROWS_EXT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and memory strobes; addresses hold when not being driven.
    always_comb begin
        state_nxt = state;
        coo_rd    = 1'b0;
        fm_rd     = 1'b0;
        coo_addr  = coo_addr_q;
        fm_addr   = fm_addr_q;
        case (state)
            IDLE:       if (bus.start) state_nxt = CLEAR;
            CLEAR:      state_nxt = FETCH_EDGE;
            FETCH_EDGE: begin
                coo_rd    = 1'b1;
                coo_addr  = edge_cnt;
                state_nxt = LATCH_EDGE;
            end
            LATCH_EDGE: begin
                fm_rd     = 1'b1;
                fm_addr   = bus.coo_src;
                state_nxt = ADD_DST;
            end
            ADD_DST: begin
                fm_rd     = 1'b1;
                fm_addr   = dst_q;
                state_nxt = ADD_SRC;
            end
            ADD_SRC:    state_nxt = (edge_cnt == LAST_EDGE) ? DONE : FETCH_EDGE;
            DONE:       state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Edge bookkeeping and accumulation of the fetched rows into AGG.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cnt     <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            bad_q        <= 1'b0;
            edge_error_q <= 1'b0;
            coo_addr_q   <= '0;
            fm_addr_q    <= '0;
            for (int r = 0; r < FEATURE_ROWS; r++)
                for (int c = 0; c < WEIGHT_COLS; c++)
                    agg[r][c] <= '0;
        end else begin
            coo_addr_q <= coo_addr;
            fm_addr_q  <= fm_addr;
            case (state)
                CLEAR: begin
                    edge_cnt     <= '0;
                    edge_error_q <= 1'b0;
                    for (int r = 0; r < FEATURE_ROWS; r++)
                        for (int c = 0; c < WEIGHT_COLS; c++)
                            agg[r][c] <= '0;
                end
                LATCH_EDGE: begin
                    src_q <= bus.coo_src;
                    dst_q <= bus.coo_dst;
                    bad_q <= edge_oor;
                    if (edge_oor) edge_error_q <= 1'b1;
                end
                ADD_DST: begin
                    if (!bad_q)
                        for (int r = 0; r < FEATURE_ROWS; r++)
                            if (NODE_WIDTH'(r) == dst_q)
                                for (int c = 0; c < WEIGHT_COLS; c++)
                                    agg[r][c] <= agg[r][c] + bus.fm_wm_row_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
                ADD_SRC: begin
                    if (!bad_q && (src_q != dst_q))
                        for (int r = 0; r < FEATURE_ROWS; r++)
                            if (NODE_WIDTH'(r) == src_q)
                                for (int c = 0; c < WEIGHT_COLS; c++)
                                    agg[r][c] <= agg[r][c] + bus.fm_wm_row_data[c*DATA_WIDTH +: DATA_WIDTH];
                    if (edge_cnt != LAST_EDGE) edge_cnt <= edge_cnt + EDGE_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Flatten AGG onto the output bus, row-major with column 0 in the LSBs.
    always_comb begin
        agg_flat = '0;
        for (int r = 0; r < FEATURE_ROWS; r++)
            for (int c = 0; c < WEIGHT_COLS; c++)
                agg_flat[(r*WEIGHT_COLS + c)*DATA_WIDTH +: DATA_WIDTH] = agg[r][c];
    end

    assign bus.coo_address    = coo_addr;
    assign bus.coo_read_en    = coo_rd;
    assign bus.fm_wm_row_addr = fm_addr;
    assign bus.fm_wm_read_en  = fm_rd;
    assign bus.agg_matrix     = agg_flat;
    assign bus.edge_error     = edge_error_q;
    assign bus.done           = (state == DONE);
endmodule

// File: tb/tb_gcn_aggregation_engine.sv
// Directed bench for the GCN aggregation engine with behavioural edge and
// FM*WM memories; expected AGG rows are hand-computed constants.
module tb_gcn_aggregation_engine;
    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int NE   = 6;
    localparam int DW   = 16;
    localparam int RW   = COLS*DW;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [2:0]    e_src [NE];
    logic [2:0]    e_dst [NE];
    logic [RW-1:0] fm_mem [ROWS];

    gcn_aggregation_engine_if #(.FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS),
                                .NUM_EDGES(NE), .DATA_WIDTH(DW)) bus ();

    gcn_aggregation_engine #(.FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS),
                             .NUM_EDGES(NE), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Edge and FM*WM memories, one-cycle read latency; out-of-range rows read as a marker.
    always @(posedge clk) begin
        if (bus.coo_read_en) begin
            bus.coo_src <= e_src[int'(bus.coo_address)];
            bus.coo_dst <= e_dst[int'(bus.coo_address)];
        end
        if (bus.fm_wm_read_en)
            bus.fm_wm_row_data <= (int'(bus.fm_wm_row_addr) < ROWS) ?
                                  fm_mem[int'(bus.fm_wm_row_addr)] : {COLS{16'h1111}};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] row(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic check_row(input string tag, input int r, input logic [RW-1:0] exp);
        check(tag, 64'(bus.agg_matrix[r*RW +: RW]), 64'(exp));
    endtask

    task automatic pattern_rows();
        for (int r = 0; r < ROWS; r++)
            fm_mem[r] = row(16'(r + 1), 16'(r + 2), 16'(r + 3));
    endtask

    // Start a run and count cycles until done. abort_at>=0 applies reset in
    // the cycle after that many edges; poke_at>=0 re-pulses start mid-run.
    task automatic run(input int abort_at, input int poke_at,
                       output int cyc, output int n_coo, output int n_fm);
        start_pulse();
        cyc = 0; n_coo = 0; n_fm = 0;
        while (!bus.done && cyc < 200) begin
            if (cyc == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            bus.start = (cyc == poke_at);
            @(posedge clk); #1;
            cyc++;
            n_coo += int'(bus.coo_read_en);
            n_fm  += int'(bus.fm_wm_read_en);
        end
        bus.start = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic check_test1(input string pfx);
        check_row({pfx, "_agg0"}, 0, row(16'd2, 16'd3, 16'd4));
        check_row({pfx, "_agg1"}, 1, row(16'd4, 16'd6, 16'd8));
        check_row({pfx, "_agg2"}, 2, row(16'd2, 16'd3, 16'd4));
        check_row({pfx, "_agg3"}, 3, row(16'd0, 16'd0, 16'd0));
        check_row({pfx, "_agg4"}, 4, row(16'd24, 16'd28, 16'd32));
        check_row({pfx, "_agg5"}, 5, row(16'd20, 16'd24, 16'd28));
    endtask

    int cyc, n_coo, n_fm;

    initial begin
        bus.start = 1'b0;
        bus.coo_src = '0;
        bus.coo_dst = '0;
        bus.fm_wm_row_data = '0;
        reset = 1'b1;
        pattern_rows();
        e_src = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd4};
        e_dst = '{3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_agg_nonzero", 64'(|bus.agg_matrix), 64'd0);
        check("rst_err", 64'(bus.edge_error), 64'd0);
        check("rst_strobes", 64'({bus.coo_read_en, bus.fm_wm_read_en}), 64'd0);
        check("rst_addrs", 64'({bus.coo_address, bus.fm_wm_row_addr}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", 64'(bus.coo_read_en), 64'd0);

        // Test 1: basic aggregation, duplicate edges, latency.
        run(-1, -1, cyc, n_coo, n_fm);
        check("t1_latency", 64'(cyc), 64'(1 + 4*NE));
        check("t1_coo_reads", 64'(n_coo), 64'(NE));
        check("t1_fm_reads", 64'(n_fm), 64'(2*NE));
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_err", 64'(bus.edge_error), 64'd0);
        check_test1("t1");

        // Test 6: start while in DONE changes nothing.
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_done_held", 64'(bus.done), 64'd1);
        check("t6_no_reads", 64'({bus.coo_read_en, bus.fm_wm_read_en}), 64'd0);
        check_test1("t6");

        // Tests 2-5 each start from reset.
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;

        // Test 2: self-loop adds its row once; start poked in ADD_SRC.
        pattern_rows();
        fm_mem[3] = row(16'd7, 16'd7, 16'd7);
        e_src = '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        e_dst = '{3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        run(-1, 4, cyc, n_coo, n_fm);
        check("t2_latency", 64'(cyc), 64'(1 + 4*NE));
        check_row("t2_agg3_selfloop", 3, row(16'd7, 16'd7, 16'd7));
        check_row("t2_agg0", 0, row(16'd10, 16'd15, 16'd20));
        check_row("t2_agg1", 1, row(16'd5, 16'd10, 16'd15));
        check("t2_err", 64'(bus.edge_error), 64'd0);

        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;

        // Test 3: modular wrap, no error; start poked in LATCH_EDGE.
        for (int r = 0; r < ROWS; r++) fm_mem[r] = '0;
        fm_mem[0] = row(16'hFFFF, 16'h0010, 16'h0000);
        fm_mem[1] = row(16'h0002, 16'h0020, 16'hFFFF);
        e_src = '{3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4};
        e_dst = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5};
        run(-1, 2, cyc, n_coo, n_fm);
        check("t3_latency", 64'(cyc), 64'(1 + 4*NE));
        check_row("t3_agg2_wrap", 2, row(16'h0001, 16'h0030, 16'hFFFF));
        check_row("t3_agg0", 0, row(16'h0000, 16'h0000, 16'h0000));
        check("t3_err", 64'(bus.edge_error), 64'd0);

        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;

        // Test 4: out-of-range endpoint flags error and is skipped.
        pattern_rows();
        e_src = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd4, 3'd4};
        e_dst = '{3'd6, 3'd1, 3'd2, 3'd5, 3'd5, 3'd5};
        run(-1, 3, cyc, n_coo, n_fm);
        check("t4_latency", 64'(cyc), 64'(1 + 4*NE));
        check("t4_done", 64'(bus.done), 64'd1);
        check_row("t4_agg0", 0, row(16'd2, 16'd3, 16'd4));
        check_row("t4_agg1", 1, row(16'd4, 16'd6, 16'd8));
        check_row("t4_agg2", 2, row(16'd2, 16'd3, 16'd4));
        check_row("t4_agg4", 4, row(16'd18, 16'd21, 16'd24));
        check_row("t4_agg5", 5, row(16'd15, 16'd18, 16'd21));
        repeat (4) @(posedge clk);
        #1;
        check("t4_err_sticky", 64'(bus.edge_error), 64'd1);

        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;

        // Test 5: reset during ADD_DST of edge 3, then a clean restart.
        e_src = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd4};
        e_dst = '{3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5};
        run(15, -1, cyc, n_coo, n_fm);
        check("t5_abort_done", 64'(bus.done), 64'd0);
        check("t5_abort_agg_nonzero", 64'(|bus.agg_matrix), 64'd0);
        check("t5_abort_strobes", 64'({bus.coo_read_en, bus.fm_wm_read_en}), 64'd0);
        check("t5_abort_addrs", 64'({bus.coo_address, bus.fm_wm_row_addr}), 64'd0);
        @(posedge clk); #1;
        check("t5_idle_holds", 64'(bus.coo_read_en), 64'd0);
        run(-1, 0, cyc, n_coo, n_fm);
        check("t5_latency", 64'(cyc), 64'(1 + 4*NE));
        check("t5_coo_reads", 64'(n_coo), 64'(NE));
        check_test1("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
